// File: rtl/mode_exec_timer.sv
// mode_exec_timer: turns requested mode codes into the driven fan level and runs the
// hurricane, stop-delay and self-clean timers with a seconds countdown.
module mode_exec_timer #(
  parameter int TICK_DIV       = 100_000_000,
  parameter int HURRICANE_SEC  = 60,
  parameter int STOP_DELAY_SEC = 60,
  parameter int CLEAN_SEC      = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_on,
  input  logic [2:0] mode_state,
  output logic [1:0] fan_level,
  output logic       clean_active,
  output logic [7:0] remain_sec,
  output logic       hurricane_used,
  output logic       done_pulse
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, RUN1, RUN2, HURR, STOPW, CLEAN} state_t;
  state_t        r_state, w_state_nx, w_target;
  logic [2:0]    r_prev_mode;
  logic [PW-1:0] r_presc, w_presc_nx;
  logic [7:0]    r_remain, w_remain_nx;
  logic          r_used, w_used_nx, r_done, w_done_nx;
  logic          w_timed, w_tick, w_expire, w_event;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      r_prev_mode <= 3'b000;
      r_presc     <= '0;
      r_remain    <= '0;
      r_used      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_prev_mode <= mode_state;
      r_presc     <= w_presc_nx;
      r_remain    <= w_remain_nx;
      r_used      <= w_used_nx;
      r_done      <= w_done_nx;
    end
  assign w_timed  = r_state == HURR || r_state == STOPW || r_state == CLEAN;
  assign w_tick   = w_timed && r_presc == PW'(TICK_DIV - 1);
  assign w_expire = w_tick && r_remain == 8'd1;
  assign w_event  = mode_state != r_prev_mode;
  always_comb begin
    w_target = r_state;
    case (r_state)
      IDLE, RUN1, RUN2:
        w_target = mode_state == 3'b001 ? RUN1 :
                   mode_state == 3'b010 ? RUN2 :
                   mode_state == 3'b000 ? IDLE :
                   (mode_state == 3'b011 && !r_used) ? HURR :
                   (mode_state == 3'b100 && r_state == IDLE) ? CLEAN : r_state;
      HURR:
        w_target = mode_state == 3'b001 ? RUN1 :
                   mode_state == 3'b010 ? RUN2 :
                   mode_state == 3'b000 ? STOPW : r_state;
      STOPW:
        w_target = mode_state == 3'b001 ? RUN1 :
                   mode_state == 3'b010 ? RUN2 : r_state;
      default: w_target = r_state;
    endcase
  end
  // power-off beats expiry, expiry beats a same-cycle request
  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    w_presc_nx  = '0;
    w_used_nx   = r_used;
    w_done_nx   = 1'b0;
    if (!machine_on) begin
      w_state_nx  = IDLE;
      w_remain_nx = '0;
      w_used_nx   = 1'b0;
    end else if (w_expire) begin
      w_state_nx  = r_state == HURR ? RUN2 : IDLE;
      w_remain_nx = '0;
      w_done_nx   = 1'b1;
    end else if (w_event && w_target != r_state) begin
      w_state_nx  = w_target;
      w_remain_nx = w_target == HURR  ? 8'(HURRICANE_SEC) :
                    w_target == STOPW ? 8'(STOP_DELAY_SEC) :
                    w_target == CLEAN ? 8'(CLEAN_SEC) : 8'd0;
      w_used_nx   = r_used | (w_target == HURR);
    end else if (w_tick) begin
      w_remain_nx = r_remain - 8'd1;
    end else if (w_timed) begin
      w_presc_nx  = r_presc + 1'b1;
    end
  end
  assign fan_level      = r_state == RUN1 ? 2'd1 :
                          r_state == RUN2 ? 2'd2 :
                          (r_state == HURR || r_state == STOPW) ? 2'd3 : 2'd0;
  assign clean_active   = r_state == CLEAN;
  assign remain_sec     = r_remain;
  assign hurricane_used = r_used;
  assign done_pulse     = r_done;
endmodule

// File: tb/tb_mode_exec_timer.sv
// tb_mode_exec_timer: scoreboard bench; expected outputs are queued with each stimulus
// step and compared one cycle later.
module tb_mode_exec_timer;
  logic       clk, rst, machine_on;
  logic [2:0] mode_state;
  logic [1:0] fan_level;
  logic       clean_active, hurricane_used, done_pulse;
  logic [7:0] remain_sec;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    string tag;
    int    fan, cln, rem, used, done;
  } exp_t;
  exp_t sb[$];
  mode_exec_timer #(.TICK_DIV(4), .HURRICANE_SEC(3), .STOP_DELAY_SEC(2), .CLEAN_SEC(5)) dut (
    .clk(clk), .rst(rst), .machine_on(machine_on), .mode_state(mode_state),
    .fan_level(fan_level), .clean_active(clean_active), .remain_sec(remain_sec),
    .hurricane_used(hurricane_used), .done_pulse(done_pulse)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic expect_out(input string tag, input int fan, cln, rem, used, done);
    exp_t e;
    e.tag = tag; e.fan = fan; e.cln = cln; e.rem = rem; e.used = used; e.done = done;
    sb.push_back(e);
  endtask
  task automatic compare_out();
    exp_t e;
    check("sb_depth", 8'(sb.size()), 8'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, ".fan"},  {6'd0, fan_level},      8'(e.fan));
    check({e.tag, ".cln"},  {7'd0, clean_active},   8'(e.cln));
    check({e.tag, ".rem"},  remain_sec,             8'(e.rem));
    check({e.tag, ".used"}, {7'd0, hurricane_used}, 8'(e.used));
    check({e.tag, ".done"}, {7'd0, done_pulse},     8'(e.done));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    compare_out();
  endtask
  initial begin
    rst = 1'b0; machine_on = 1'b0; mode_state = 3'b000;
    #12;
    expect_out("reset", 0, 0, 0, 0, 0); compare_out();
    @(posedge clk); #1;
    rst = 1'b1; machine_on = 1'b1;
    mode_state = 3'b001; expect_out("l1", 1, 0, 0, 0, 0); step();
    mode_state = 3'b010; expect_out("l2", 2, 0, 0, 0, 0); step();
    mode_state = 3'b011; expect_out("hurr_in", 3, 0, 3, 1, 0); step();
    for (int i = 1; i < 12; i++) begin expect_out("hurr_cnt", 3, 0, 3 - i / 4, 1, 0); step(); end
    expect_out("hurr_exp", 2, 0, 0, 1, 1); step();
    expect_out("hurr_post", 2, 0, 0, 1, 0); step();
    mode_state = 3'b000; expect_out("idle", 0, 0, 0, 1, 0); step();
    mode_state = 3'b011; expect_out("hurr_block", 0, 0, 0, 1, 0); step();
    machine_on = 1'b0; mode_state = 3'b000; expect_out("off", 0, 0, 0, 0, 0); step();
    expect_out("off_hold", 0, 0, 0, 0, 0); step();
    machine_on = 1'b1; mode_state = 3'b011; expect_out("hurr_again", 3, 0, 3, 1, 0); step();
    mode_state = 3'b000; expect_out("stopw_in", 3, 0, 2, 1, 0); step();
    for (int i = 1; i < 8; i++) begin expect_out("stopw_cnt", 3, 0, 2 - i / 4, 1, 0); step(); end
    expect_out("stopw_exp", 0, 0, 0, 1, 1); step();
    expect_out("stopw_post", 0, 0, 0, 1, 0); step();
    machine_on = 1'b0; expect_out("off2", 0, 0, 0, 0, 0); step();
    machine_on = 1'b1; mode_state = 3'b011; expect_out("hurr3", 3, 0, 3, 1, 0); step();
    mode_state = 3'b000; expect_out("stopw2_in", 3, 0, 2, 1, 0); step();
    expect_out("stopw2_run", 3, 0, 2, 1, 0); step();
    mode_state = 3'b010; expect_out("stopw_abort", 2, 0, 0, 1, 0); step();
    mode_state = 3'b000; expect_out("idle2", 0, 0, 0, 1, 0); step();
    mode_state = 3'b100; expect_out("clean_in", 0, 1, 5, 1, 0); step();
    mode_state = 3'b001;
    for (int i = 1; i < 20; i++) begin expect_out("clean_cnt", 0, 1, 5 - i / 4, 1, 0); step(); end
    expect_out("clean_exp", 0, 0, 0, 1, 1); step();
    expect_out("clean_held", 0, 0, 0, 1, 0); step();
    mode_state = 3'b000; expect_out("idle3", 0, 0, 0, 1, 0); step();
    mode_state = 3'b100; expect_out("clean2_in", 0, 1, 5, 1, 0); step();
    for (int i = 1; i < 20; i++) begin expect_out("clean2_cnt", 0, 1, 5 - i / 4, 1, 0); step(); end
    machine_on = 1'b0; expect_out("off_at_exp", 0, 0, 0, 0, 0); step();
    expect_out("off_at_exp_hold", 0, 0, 0, 0, 0); step();
    machine_on = 1'b1; mode_state = 3'b011; expect_out("hurr4", 3, 0, 3, 1, 0); step();
    expect_out("hurr4_run", 3, 0, 3, 1, 0); step();
    #2 rst = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0); compare_out();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
